// File: rtl/riscV_unrn_pkg.sv
// Shared definitions for the CLINT timer block.
// Holds the register byte offsets, the compare-channel window base/stride
// and the decoded register-select type used by the top-level decoder.
package riscV_unrn_pkg;

  localparam logic [6:0] CLINT_MTIME_LO = 7'h00;
  localparam logic [6:0] CLINT_MTIME_HI = 7'h04;
  localparam logic [6:0] CLINT_PRESCALE = 7'h08;
  localparam logic [6:0] CLINT_CTRL     = 7'h0C;
  localparam logic [6:0] CLINT_IE       = 7'h10;
  localparam logic [6:0] CLINT_IP       = 7'h14;

  // Compare channel k lives at CLINT_CMP_BASE + k*CLINT_CMP_STRIDE (LO),
  // with the HI word 4 bytes above.
  localparam logic [6:0]  CLINT_CMP_BASE   = 7'h20;
  localparam int unsigned CLINT_CMP_STRIDE = 8;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_PRESCALE,
    SEL_CTRL,
    SEL_IE,
    SEL_IP,
    SEL_CMP_LO,
    SEL_CMP_HI
  } clint_sel_e;

endpackage

// File: rtl/clint_timer_if.sv
// Register-bus interface of the CLINT timer.
//   req_i   : access request, one per cycle
//   we_i    : 1 = write, 0 = read
//   addr_i  : byte offset into the register map
//   wdata_i : write data
//   rdata_o : read data, valid while ack_o is high
//   ack_o   : access complete, one cycle after req_i
//   err_o   : access error, asserted together with ack_o
interface clint_timer_if;
  logic        req_i;
  logic        we_i;
  logic [6:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o, err_o
  );
endinterface

// File: rtl/clint_cmp_channel.sv
// One timer compare channel: the CMP register and its pending flag.
//   clk, rst  : clock, synchronous active-high reset
//   mtime_i   : current counter value
//   wr_lo_i   : write wdata_i into CMP[31:0]
//   wr_hi_i   : write wdata_i into CMP[CNT_W-1:32]
//   wdata_i   : bus write data
//   cmp_o     : current CMP value
//   ip_o      : registered pending flag (mtime >= CMP)
module clint_cmp_channel #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] mtime_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [CNT_W-1:0] cmp_o,
  output logic             ip_o
);

  localparam int unsigned HI_W = CNT_W - 32;

  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic             ip_q, ip_d;

  always_comb begin
    cmp_d = cmp_q;
    if (wr_lo_i) cmp_d = {cmp_q[CNT_W-1:32], wdata_i};
    if (wr_hi_i) cmp_d = {wdata_i[HI_W-1:0], cmp_q[31:0]};
    // A CMP write clears the flag and wins over a same-cycle match; the
    // new value is compared from the following cycle onward.
    ip_d = (wr_lo_i || wr_hi_i) ? 1'b0 : (mtime_i >= cmp_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q <= '1;
      ip_q  <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      ip_q  <= ip_d;
    end
  end

  assign cmp_o = cmp_q;
  assign ip_o  = ip_q;

endmodule

// File: rtl/clint_timer.sv
// CLINT-style machine timer: prescaled mtime counter, NUM_CMP compare
// channels with pending/enable bits, and a single-cycle register bus.
//   clk, rst : clock, synchronous active-high reset
//   bus      : register bus (slave side), ack one cycle after each request
//   irq_o    : per-channel interrupt, IP & IE
//   mtime_o  : current counter value
module clint_timer
  import riscV_unrn_pkg::*;
#(
  parameter int unsigned NUM_CMP = 2,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned PRE_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  clint_timer_if.slave       bus,
  output logic [NUM_CMP-1:0] irq_o,
  output logic [CNT_W-1:0]   mtime_o
);

  localparam int unsigned HI_W = CNT_W - 32;

  logic [CNT_W-1:0]   mtime_q, mtime_d;
  logic [PRE_W-1:0]   pcnt_q, pcnt_d;
  logic [PRE_W-1:0]   prescale_q;
  logic               en_q;
  logic [NUM_CMP-1:0] ie_q;
  logic [HI_W-1:0]    shadow_q;
  logic               ack_q, err_q;
  logic [31:0]        rdata_q;

  clint_sel_e         sel;
  logic [6:0]         rel;
  logic [3:0]         ch_idx;
  logic               err_c, wr_c, rd_c;
  logic [31:0]        rdata_c;
  logic [CNT_W-1:0]   cmp_rd;
  logic [CNT_W-1:0]   cmp_val [NUM_CMP];
  logic [NUM_CMP-1:0] ip;

  // Address decode. Anything that does not resolve to a register is an error.
  always_comb begin
    sel    = SEL_NONE;
    rel    = '0;
    ch_idx = '0;
    if (bus.addr_i[1:0] == 2'b00) begin
      case (bus.addr_i)
        CLINT_MTIME_LO: sel = SEL_MTIME_LO;
        CLINT_MTIME_HI: sel = SEL_MTIME_HI;
        CLINT_PRESCALE: sel = SEL_PRESCALE;
        CLINT_CTRL:     sel = SEL_CTRL;
        CLINT_IE:       sel = SEL_IE;
        CLINT_IP:       sel = SEL_IP;
        default: begin
          if (bus.addr_i >= CLINT_CMP_BASE) begin
            rel    = bus.addr_i - CLINT_CMP_BASE;
            ch_idx = 4'(32'(rel) / CLINT_CMP_STRIDE);
            if (32'(ch_idx) < NUM_CMP)
              sel = ((32'(rel) % CLINT_CMP_STRIDE) == 32'd4) ? SEL_CMP_HI : SEL_CMP_LO;
          end
        end
      endcase
    end
    err_c = bus.req_i && ((sel == SEL_NONE) || (sel == SEL_IP && bus.we_i));
    wr_c  = bus.req_i && !err_c && bus.we_i;
    rd_c  = bus.req_i && !err_c && !bus.we_i;
  end

  // Read data mux
  always_comb begin
    cmp_rd = '0;
    for (int unsigned k = 0; k < NUM_CMP; k++)
      if (32'(ch_idx) == k) cmp_rd = cmp_val[k];
    rdata_c = '0;
    case (sel)
      SEL_MTIME_LO: rdata_c = mtime_q[31:0];
      SEL_MTIME_HI: rdata_c = 32'(shadow_q);
      SEL_PRESCALE: rdata_c = 32'(prescale_q);
      SEL_CTRL:     rdata_c = {31'b0, en_q};
      SEL_IE:       rdata_c = 32'(ie_q);
      SEL_IP:       rdata_c = 32'(ip);
      SEL_CMP_LO:   rdata_c = cmp_rd[31:0];
      SEL_CMP_HI:   rdata_c = 32'(cmp_rd[CNT_W-1:32]);
      default:      rdata_c = '0;
    endcase
  end

  // Prescaler and counter; a bus write to either mtime half overrides the
  // increment, keeps the other half as-is and restarts the prescaler.
  always_comb begin
    mtime_d = mtime_q;
    pcnt_d  = pcnt_q;
    if (en_q) begin
      if (pcnt_q == prescale_q) begin
        pcnt_d  = '0;
        mtime_d = mtime_q + CNT_W'(1);
      end else begin
        pcnt_d  = pcnt_q + PRE_W'(1);
      end
    end
    if (wr_c && sel == SEL_MTIME_LO) begin
      mtime_d = {mtime_q[CNT_W-1:32], bus.wdata_i};
      pcnt_d  = '0;
    end
    if (wr_c && sel == SEL_MTIME_HI) begin
      mtime_d = {bus.wdata_i[HI_W-1:0], mtime_q[31:0]};
      pcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      pcnt_q     <= '0;
      prescale_q <= '0;
      en_q       <= 1'b1;
      ie_q       <= '0;
      shadow_q   <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mtime_q <= mtime_d;
      pcnt_q  <= pcnt_d;
      if (wr_c && sel == SEL_PRESCALE) prescale_q <= bus.wdata_i[PRE_W-1:0];
      if (wr_c && sel == SEL_CTRL)     en_q       <= bus.wdata_i[0];
      if (wr_c && sel == SEL_IE)       ie_q       <= bus.wdata_i[NUM_CMP-1:0];
      // Capturing the upper half on an LO read makes LO-then-HI atomic.
      if (rd_c && sel == SEL_MTIME_LO) shadow_q   <= mtime_q[CNT_W-1:32];
      ack_q   <= bus.req_i;
      err_q   <= err_c;
      rdata_q <= rd_c ? rdata_c : '0;
    end
  end

  for (genvar k = 0; k < NUM_CMP; k++) begin : g_ch
    logic hit;
    assign hit = wr_c && (32'(ch_idx) == k);

    clint_cmp_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .mtime_i (mtime_q),
      .wr_lo_i (hit && sel == SEL_CMP_LO),
      .wr_hi_i (hit && sel == SEL_CMP_HI),
      .wdata_i (bus.wdata_i),
      .cmp_o   (cmp_val[k]),
      .ip_o    (ip[k])
    );
  end

  assign irq_o       = ip & ie_q;
  assign mtime_o     = mtime_q;
  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;

endmodule
